fsic_io_serdes_tx_frm: RTL

Parametrised, single-clock transmit framer and serializer for the FSIC chip-to-chip link, successor to the fixed 12-lane, ratio-4 TX path. It accepts parallel words over a valid/ready handshake in the `ioclk` domain and drives `pLANES` data lanes plus one frame-valid sideband lane at `pCLK_RATIO` bits per lane per frame. Compared with the previous TX path it adds a 1-entry holding buffer, explicit idle frames, and a training mode that emits a fixed alignment pattern on link enable and on request.

---
 rtl/fsic_io_serdes_tx_frm.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fsic_io_serdes_tx_frm.sv
`timescale 1ns/1ps
// FSIC link transmit framer: parallel words through a 1-entry holding buffer,
// serialized LSB-first per lane with a frame-valid sideband lane and training frames.
module fsic_io_serdes_tx_frm #(
  parameter int pLANES        = 8,
  parameter int pCLK_RATIO    = 4,
  parameter int pTRAIN_FRAMES = 8,
  parameter int pW            = pLANES * pCLK_RATIO
) (
  input  logic                          ioclk,
  input  logic                          axis_rst,
  input  logic                          txen,
  input  logic                          train_req,
  input  logic [pW-1:0]                 in_tdata,
  input  logic                          in_tvalid,
  output logic                          in_tready,
  output logic [pLANES:0]               serial_txd,
  output logic                          serial_tclk_en,
  output logic [$clog2(pCLK_RATIO)-1:0] phase_cnt,
  output logic                          frame_start,
  output logic [1:0]                    link_state
);

  localparam int PCW        = $clog2(pCLK_RATIO);
  localparam int TCW        = (pTRAIN_FRAMES > 1) ? $clog2(pTRAIN_FRAMES) : 1;
  localparam int TRAIN_LAST = (pTRAIN_FRAMES > 0) ? pTRAIN_FRAMES - 1 : 0;
  localparam logic [PCW-1:0] PH_LAST = PCW'(pCLK_RATIO - 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'(TRAIN_LAST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                               state_q, state_d;
  logic [PCW-1:0]                       phase_q, phase_d;
  logic [pW-1:0]                        cur_q, cur_d;
  logic                                 cur_vld_q, cur_vld_d;
  logic [pW-1:0]                        hold_q, hold_d;
  logic                                 hold_vld_q, hold_vld_d;
  logic [TCW-1:0]                       train_cnt_q, train_cnt_d;
  logic                                 retrain_pend_q, retrain_pend_d;

  logic                                 boundary_s;
  logic                                 ready_s;
  logic                                 accept_s;
  logic [pLANES-1:0][pCLK_RATIO-1:0]    lanes_s;
  logic [pLANES-1:0]                    data_bits_s;

  assign boundary_s = (state_q != ST_IDLE) && (phase_q == PH_LAST);
  assign ready_s    = (state_q == ST_RUN) && !retrain_pend_q && txen &&
                      (!hold_vld_q || (phase_q == PH_LAST));
  assign accept_s   = in_tvalid && ready_s;

  // Next-state: link FSM, phase counter, frame/hold buffer and training count
  always_comb begin
    state_d        = state_q;
    cur_d          = cur_q;
    cur_vld_d      = cur_vld_q;
    hold_d         = hold_q;
    hold_vld_d     = hold_vld_q;
    train_cnt_d    = train_cnt_q;
    retrain_pend_d = retrain_pend_q;

    if ((state_q == ST_IDLE) || boundary_s) begin
      phase_d = PCW'(0);
    end else begin
      phase_d = phase_q + PCW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (txen) begin
          state_d     = (pTRAIN_FRAMES == 0) ? ST_RUN : ST_TRAIN;
          train_cnt_d = TCW'(0);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRAIN: begin
        if (boundary_s) begin
          if (!txen) begin
            state_d     = ST_IDLE;
            cur_vld_d   = 1'b0;
            train_cnt_d = TCW'(0);
          end else if (train_cnt_q == TC_LAST) begin
            // Held word goes out in the very first RUN frame
            state_d     = ST_RUN;
            train_cnt_d = TCW'(0);
            cur_d       = hold_q;
            cur_vld_d   = hold_vld_q;
            hold_vld_d  = 1'b0;
          end else begin
            train_cnt_d = train_cnt_q + TCW'(1);
          end
        end else begin
          train_cnt_d = train_cnt_q;
        end
      end
      ST_RUN: begin
        if (boundary_s) begin
          retrain_pend_d = 1'b0;
          if (!txen) begin
            state_d   = ST_IDLE;
            cur_vld_d = 1'b0;
          end else if (retrain_pend_q && (pTRAIN_FRAMES != 0)) begin
            state_d = ST_TRAIN;
          end else begin
            cur_d      = hold_q;
            cur_vld_d  = hold_vld_q;
            hold_vld_d = 1'b0;
          end
        end else begin
          state_d = ST_RUN;
        end
        if (train_req && (state_d == ST_RUN)) begin
          retrain_pend_d = 1'b1;
        end else begin
          retrain_pend_d = retrain_pend_d;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept_s) begin
      hold_d     = in_tdata;
      hold_vld_d = 1'b1;
    end else begin
      hold_d = hold_d;
    end
  end

  // State registers
  always_ff @(posedge ioclk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q        <= ST_IDLE;
      phase_q        <= PCW'(0);
      cur_q          <= '0;
      cur_vld_q      <= 1'b0;
      hold_q         <= '0;
      hold_vld_q     <= 1'b0;
      train_cnt_q    <= TCW'(0);
      retrain_pend_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      cur_q          <= cur_d;
      cur_vld_q      <= cur_vld_d;
      hold_q         <= hold_d;
      hold_vld_q     <= hold_vld_d;
      train_cnt_q    <= train_cnt_d;
      retrain_pend_q <= retrain_pend_d;
    end
  end

  assign lanes_s = cur_q;

  for (genvar l = 0; l < pLANES; l++) begin : g_lane
    assign data_bits_s[l] = lanes_s[l][phase_q];
  end

  // Lane decode from registered state only
  always_comb begin
    serial_txd = '0;
    case (state_q)
      ST_TRAIN: serial_txd = {(pLANES + 1){phase_q == PCW'(0)}};
      ST_RUN:   serial_txd = {cur_vld_q, data_bits_s & {pLANES{cur_vld_q}}};
      default:  serial_txd = '0;
    endcase
  end

  assign in_tready      = ready_s;
  assign serial_tclk_en = (state_q != ST_IDLE);
  assign frame_start    = (state_q != ST_IDLE) && (phase_q == PCW'(0));
  assign phase_cnt      = phase_q;
  assign link_state     = state_q;

endmodule
